// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Purpose:
//   Sits behind the UART receiver and turns its byte strobes into program
//   words. Every four bytes form one 32-bit little-endian word, with the first
//   byte received in bits [7:0]. Each word is written to instruction memory at
//   sequential word addresses through a req/gnt write port. Loading stops when
//   the sentinel word END_WORD arrives. The sentinel itself is never written.
//
// Parameters:
//   ADDR_WIDTH    word-address width of the memory port (address wraps)
//   END_WORD      sentinel word that terminates loading
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   en_i          load enable (level); low holds the loader cleared
//   rx_dv_i       one-cycle strobe, rx_byte_i valid
//   rx_byte_i     received byte
//   mem_req_o     write request, held until granted
//   mem_gnt_i     write accepted this cycle (only meaningful while requesting)
//   mem_addr_o    word address, stable while mem_req_o=1
//   mem_wdata_o   write data, stable while mem_req_o=1
//   busy_o        loading or draining the final write
//   done_o        sentinel received and all writes drained
//   overflow_o    sticky: at least one word dropped because a write was stalled
//   word_count_o  words granted since en_i rose, saturating at all-ones
// -----------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] END_WORD   = 32'h0000_0FFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;

  logic [1:0]            bc_q;       // byte position inside the current word
  logic [23:0]           asm_q;      // lower three bytes of the word being built
  logic [ADDR_WIDTH-1:0] wptr_q;     // address of the next word to be written
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH:0]   wcount_q;

  logic                  grant;
  logic [31:0]           word_w;
  logic [ADDR_WIDTH-1:0] wptr_inc;

  // Decoded actions for this cycle, produced by the FSM and applied by the
  // datapath register block.
  logic                  start_load;
  logic                  byte_ok;
  logic                  load_word;
  logic                  drop_word;
  logic                  count_grant;

  assign grant    = req_q & mem_gnt_i;
  // The fourth byte is not stored; it completes the word straight from the input.
  assign word_w   = {rx_byte_i, asm_q};
  assign wptr_inc = wptr_q + ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath actions
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    start_load  = 1'b0;
    byte_ok     = 1'b0;
    load_word   = 1'b0;
    drop_word   = 1'b0;
    count_grant = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A write left over from the previous session must finish first.
          // Otherwise its grant could be mistaken for a new-session word.
          if (!req_q) begin
            state_d    = S_LOAD;
            start_load = 1'b1;
          end
        end

        S_LOAD: begin
          count_grant = grant;
          if (rx_dv_i) begin
            byte_ok = 1'b1;
            if (bc_q == 2'd3) begin
              if (word_w == END_WORD) begin
                state_d = (req_q && !mem_gnt_i) ? S_DRAIN : S_DONE;
              end else if (!req_q || mem_gnt_i) begin
                load_word = 1'b1;
              end else begin
                drop_word = 1'b1;
              end
            end
          end
        end

        S_DRAIN: begin
          count_grant = grant;
          if (grant) state_d = S_DONE;
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte assembly, write pointer, counters and the memory port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bc_q       <= '0;
      asm_q      <= '0;
      wptr_q     <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
      wcount_q   <= '0;
    end else begin
      if (!en_i) begin
        // A partial word is discarded along with the session status.
        bc_q       <= '0;
        asm_q      <= '0;
        overflow_q <= 1'b0;
        wcount_q   <= '0;
      end else if (start_load) begin
        bc_q       <= '0;
        asm_q      <= '0;
        wptr_q     <= '0;
        overflow_q <= 1'b0;
        wcount_q   <= '0;
      end else begin
        if (byte_ok) begin
          bc_q <= bc_q + 2'd1;
          unique case (bc_q)
            2'd0:    asm_q[7:0]   <= rx_byte_i;
            2'd1:    asm_q[15:8]  <= rx_byte_i;
            2'd2:    asm_q[23:16] <= rx_byte_i;
            default: asm_q        <= asm_q;
          endcase
        end
        if (drop_word) overflow_q <= 1'b1;
        if (count_grant) begin
          wptr_q <= wptr_inc;
          if (wcount_q != '1) wcount_q <= wcount_q + (ADDR_WIDTH + 1)'(1);
        end
      end

      // The memory port ignores en_i. An outstanding write always completes,
      // so the memory never sees a request withdrawn before its grant.
      if (load_word) begin
        req_q   <= 1'b1;
        // If the previous write is granted in this same cycle, the new word
        // goes to the slot after it.
        addr_q  <= grant ? wptr_inc : wptr_q;
        wdata_q <= word_w;
      end else if (grant) begin
        req_q   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign overflow_o   = overflow_q;
  assign word_count_o = wcount_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader built with ADDR_WIDTH=2, so address wrap
// and word-count saturation (at 7) are reachable with a few words. Inputs are
// driven 1 time unit after the rising edge, and outputs are compared at that
// same point. Writes are logged from the port handshake and compared against
// hand-written expected lists.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          rx_dv_i;
  logic [7:0]    rx_byte_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
  logic [AW:0]   word_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            sentinel_req_cycles = 0;

  uart_prog_loader #(
    .ADDR_WIDTH (AW),
    .END_WORD   (32'h0000_0FFF)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .rx_dv_i      (rx_dv_i),
    .rx_byte_i    (rx_byte_i),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .word_count_o (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory side: record every accepted write and watch for the sentinel.
  always @(posedge clk_i) begin
    if (!rst_i && mem_req_o && mem_gnt_i) begin
      log_addr.push_back(mem_addr_o);
      log_data.push_back(mem_wdata_o);
    end
    if (mem_req_o && mem_wdata_o == 32'h0000_0FFF) sentinel_req_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_byte_i = b;
    tick(1);
    rx_dv_i   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      strobe(tmp[7:0]);
    end
  endtask

  task automatic check_log(input string tag, input int base, input int n,
                           input logic [31:0] exp_a[], input logic [31:0] exp_d[]);
    check({tag, "_log_size"}, 32'(log_addr.size()), 32'(base + n));
    for (int i = 0; i < n; i++) begin
      if (base + i < log_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[base+i]), exp_a[i]);
        check($sformatf("%s_data%0d", tag, i), log_data[base+i], exp_d[i]);
      end
    end
  endtask

  initial begin
    int base;
    logic [31:0] ea[];
    logic [31:0] ed[];

    rst_i     = 1'b1;
    en_i      = 1'b0;
    rx_dv_i   = 1'b0;
    rx_byte_i = 8'h00;
    mem_gnt_i = 1'b0;
    tick(3);

    // ---------------- reset state ----------------
    check("rst_req",   32'(mem_req_o),    32'd0);
    check("rst_addr",  32'(mem_addr_o),   32'd0);
    check("rst_wdata", mem_wdata_o,       32'd0);
    check("rst_busy",  32'(busy_o),       32'd0);
    check("rst_done",  32'(done_o),       32'd0);
    check("rst_ovf",   32'(overflow_o),   32'd0);
    check("rst_wc",    32'(word_count_o), 32'd0);
    rst_i = 1'b0;
    tick(1);

    // ---------------- A: basic load, grant tied high ----------------
    base      = log_addr.size();
    mem_gnt_i = 1'b1;
    en_i      = 1'b1;
    tick(1);
    check("a_busy", 32'(busy_o), 32'd1);
    send_word(32'h1234_5678);
    check("a_req0",  32'(mem_req_o),  32'd1);
    check("a_addr0", 32'(mem_addr_o), 32'd0);
    check("a_data0", mem_wdata_o,     32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    check("a_addr1", 32'(mem_addr_o), 32'd1);
    check("a_data1", mem_wdata_o,     32'hDEAD_BEEF);
    send_word(32'h0000_0FFF);
    check("a_done",  32'(done_o),       32'd1);
    check("a_busy2", 32'(busy_o),       32'd0);
    check("a_req_s", 32'(mem_req_o),    32'd0);
    check("a_wc",    32'(word_count_o), 32'd2);
    ea = '{32'd0, 32'd1};
    ed = '{32'h1234_5678, 32'hDEAD_BEEF};
    check_log("a", base, 2, ea, ed);
    en_i = 1'b0;
    tick(1);
    check("a_off_done", 32'(done_o),       32'd0);
    check("a_off_wc",   32'(word_count_o), 32'd0);

    // ---------------- B: grant stall, then sentinel while stalled ----------------
    base      = log_addr.size();
    mem_gnt_i = 1'b0;
    en_i      = 1'b1;
    tick(1);
    send_word(32'hCAFE_F00D);
    check("b_req", 32'(mem_req_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("b_stall_req%0d", i),  32'(mem_req_o),  32'd1);
      check($sformatf("b_stall_addr%0d", i), 32'(mem_addr_o), 32'd0);
      check($sformatf("b_stall_data%0d", i), mem_wdata_o,     32'hCAFE_F00D);
    end
    mem_gnt_i = 1'b1;
    tick(1);
    mem_gnt_i = 1'b0;
    check("b_gnt_req", 32'(mem_req_o),    32'd0);
    check("b_gnt_wc",  32'(word_count_o), 32'd1);
    send_word(32'h1122_3344);
    check("b_addr1", 32'(mem_addr_o), 32'd1);
    check("b_data1", mem_wdata_o,     32'h1122_3344);
    send_word(32'h0000_0FFF);
    check("b_drain_busy", 32'(busy_o),     32'd1);
    check("b_drain_done", 32'(done_o),     32'd0);
    check("b_drain_addr", 32'(mem_addr_o), 32'd1);
    check("b_drain_data", mem_wdata_o,     32'h1122_3344);
    tick(2);
    check("b_drain_busy2", 32'(busy_o), 32'd1);
    check("b_drain_done2", 32'(done_o), 32'd0);
    mem_gnt_i = 1'b1;
    tick(1);
    mem_gnt_i = 1'b0;
    check("b_done",  32'(done_o),       32'd1);
    check("b_busy",  32'(busy_o),       32'd0);
    check("b_req",   32'(mem_req_o),    32'd0);
    check("b_wc",    32'(word_count_o), 32'd2);
    ea = '{32'd0, 32'd1};
    ed = '{32'hCAFE_F00D, 32'h1122_3344};
    check_log("b", base, 2, ea, ed);
    en_i = 1'b0;
    tick(1);

    // ---------------- C: back-to-back, overflow, wrap, saturation ----------------
    base = log_addr.size();
    en_i = 1'b1;
    tick(1);
    send_word(32'h0BAD_F00D);
    tick(2);
    strobe(8'h21);
    strobe(8'h43);
    strobe(8'h65);
    mem_gnt_i = 1'b1;
    strobe(8'h87);
    mem_gnt_i = 1'b0;
    check("c_b2b_req",  32'(mem_req_o),    32'd1);
    check("c_b2b_addr", 32'(mem_addr_o),   32'd1);
    check("c_b2b_data", mem_wdata_o,       32'h8765_4321);
    check("c_b2b_ovf",  32'(overflow_o),   32'd0);
    check("c_b2b_wc",   32'(word_count_o), 32'd1);
    send_word(32'h99AA_BBCC);
    check("c_ovf",      32'(overflow_o),   32'd1);
    check("c_ovf_addr", 32'(mem_addr_o),   32'd1);
    check("c_ovf_data", mem_wdata_o,       32'h8765_4321);
    tick(3);
    check("c_ovf_sticky", 32'(overflow_o), 32'd1);
    mem_gnt_i = 1'b1;
    tick(1);
    check("c_after_req", 32'(mem_req_o),    32'd0);
    check("c_after_wc",  32'(word_count_o), 32'd2);
    check("c_after_ovf", 32'(overflow_o),   32'd1);
    for (int i = 0; i < 7; i++) send_word(32'hA000_0000 + 32'(i));
    send_word(32'h0000_0FFF);
    check("c_done",    32'(done_o),       32'd1);
    check("c_wc_sat",  32'(word_count_o), 32'd7);
    check("c_ovf_end", 32'(overflow_o),   32'd1);
    ea = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    ed = '{32'h0BAD_F00D, 32'h8765_4321, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
           32'hA000_0003, 32'hA000_0004, 32'hA000_0005, 32'hA000_0006};
    check_log("c", base, 9, ea, ed);
    mem_gnt_i = 1'b0;
    en_i      = 1'b0;
    tick(1);
    check("c_off_ovf",  32'(overflow_o),   32'd0);
    check("c_off_wc",   32'(word_count_o), 32'd0);
    check("c_off_done", 32'(done_o),       32'd0);

    // ---------------- D: abort, enable edge strobe, hold on disable, reset ----------------
    en_i = 1'b1;
    tick(1);
    strobe(8'hAA);
    strobe(8'hBB);
    en_i = 1'b0;
    tick(2);
    en_i = 1'b1;
    strobe(8'hEE);              // same cycle as enable rising: ignored
    send_word(32'h0403_0201);
    check("d_req",  32'(mem_req_o),  32'd1);
    check("d_addr", 32'(mem_addr_o), 32'd0);
    check("d_data", mem_wdata_o,     32'h0403_0201);
    en_i = 1'b0;
    tick(2);
    check("d_hold_req",  32'(mem_req_o),  32'd1);
    check("d_hold_data", mem_wdata_o,     32'h0403_0201);
    check("d_hold_busy", 32'(busy_o),     32'd0);
    rst_i = 1'b1;
    #1;
    check("d_rst_req",  32'(mem_req_o),  32'd0);
    check("d_rst_addr", 32'(mem_addr_o), 32'd0);
    check("d_rst_data", mem_wdata_o,     32'd0);
    tick(1);
    rst_i = 1'b0;
    tick(1);

    check("sentinel_never_requested", 32'(sentinel_req_cycles), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
